// File: rtl/branch_ctrl_unit_pkg.sv
// Shared definitions for the branch control unit: Bicc condition encodings,
// delay-slot FSM states and NZVC bit positions.
package branch_pkg;

    // Bicc cond field encodings
    localparam logic [3:0] COND_BN   = 4'b0000;
    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BLE  = 4'b0010;
    localparam logic [3:0] COND_BL   = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;
    localparam logic [3:0] COND_BNE  = 4'b1001;
    localparam logic [3:0] COND_BG   = 4'b1010;
    localparam logic [3:0] COND_BGE  = 4'b1011;
    localparam logic [3:0] COND_BGU  = 4'b1100;
    localparam logic [3:0] COND_BCC  = 4'b1101;
    localparam logic [3:0] COND_BPOS = 4'b1110;
    localparam logic [3:0] COND_BVC  = 4'b1111;

    // NZVC bit positions within the {N,Z,V,C} vector
    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;
    localparam int CC_C = 0;

    // Delay-slot sequencing state
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SLOT_EXEC = 2'd1,
        SLOT_KILL = 2'd2
    } slot_state_e;

    // BA and BN never look at the flags, so they can never be held by a CC hazard
    function automatic logic cond_uses_cc(input logic [3:0] cond);
        return (cond != COND_BA) && (cond != COND_BN);
    endfunction

endpackage

// File: rtl/branch_ctrl_unit_if.sv
// ID-stage branch bus: decoded branch, CC write-back from EX, and the
// redirect/squash/stall results plus architectural CC and statistics.
interface branch_ctrl_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              id_valid;
    logic              id_is_branch;
    logic [3:0]        id_cond;
    logic              id_annul;
    logic [ADDR_W-1:0] id_target;
    logic              cc_we;
    logic [3:0]        cc_in;
    logic              cc_pending;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              squash;
    logic              stall;
    logic [3:0]        cc_q;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  ntaken_cnt;

    // Pipeline side: supplies the instruction and CC traffic
    modport master (
        output flush, id_valid, id_is_branch, id_cond, id_annul, id_target,
               cc_we, cc_in, cc_pending,
        input  redirect, target, squash, stall, cc_q, taken_cnt, ntaken_cnt
    );

    // Branch unit side
    modport slave (
        input  flush, id_valid, id_is_branch, id_cond, id_annul, id_target,
               cc_we, cc_in, cc_pending,
        output redirect, target, squash, stall, cc_q, taken_cnt, ntaken_cnt
    );
endinterface

// File: rtl/bicc_cond_eval.sv
// Combinational Bicc condition evaluation: cond field + NZVC -> take.
module bicc_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzvc,
    output logic       take
);
    logic n, z, v, c;

    assign n = nzvc[CC_N];
    assign z = nzvc[CC_Z];
    assign v = nzvc[CC_V];
    assign c = nzvc[CC_C];

    // Decode every Bicc condition against the supplied flags
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_BN:   take = 1'b0;
            COND_BE:   take = z;
            COND_BLE:  take = z | (n ^ v);
            COND_BL:   take = n ^ v;
            COND_BLEU: take = c | z;
            COND_BCS:  take = c;
            COND_BNEG: take = n;
            COND_BVS:  take = v;
            COND_BA:   take = 1'b1;
            COND_BNE:  take = ~z;
            COND_BG:   take = ~(z | (n ^ v));
            COND_BGE:  take = ~(n ^ v);
            COND_BGU:  take = ~(c | z);
            COND_BCC:  take = ~c;
            COND_BPOS: take = ~n;
            COND_BVC:  take = ~v;
            default:   take = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_ctrl_unit.sv
// Branch resolution at ID: owns NZVC, resolves Bicc, sequences the
// delay-slot annul protocol, raises CC-hazard stalls and counts outcomes.
module branch_ctrl_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_ctrl_unit_if.slave  bus
);
    logic [3:0]        cc_q, cc_d;
    slot_state_e       state_q, state_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]  ntaken_cnt_q, ntaken_cnt_d;

    logic [3:0]        eff_cc;
    logic              cond_true;
    logic              eligible;
    logic              stall_c;
    logic              resolve;
    logic              take;
    logic              kill_next;
    logic              squash_c;
    logic [ADDR_W-1:0] target_c;

    // Flags written by EX this cycle are bypassed straight into evaluation
    assign eff_cc = bus.cc_we ? bus.cc_in : cc_q;

    bicc_cond_eval u_cond_eval (
        .cond (bus.id_cond),
        .nzvc (eff_cc),
        .take (cond_true)
    );

    // Resolution, stall and squash decisions for the instruction in ID;
    // everything is forced quiet while reset or flush is asserted
    always_comb begin
        eligible  = bus.id_valid & bus.id_is_branch & (state_q != SLOT_KILL);
        stall_c   = rst_n & ~bus.flush & eligible & bus.cc_pending
                    & cond_uses_cc(bus.id_cond);
        resolve   = rst_n & ~bus.flush & eligible & ~stall_c;
        take      = resolve & cond_true;
        // a=1 annuls the slot unless a conditional branch is taken
        kill_next = bus.id_annul & ((bus.id_cond == COND_BA) | ~take);
        squash_c  = rst_n & ~bus.flush & (state_q == SLOT_KILL) & bus.id_valid;
        target_c  = take ? bus.id_target : '0;
    end

    // Next-state for the delay-slot sequencer; bubbles in ID hold the state
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else if (state_q == SLOT_KILL) begin
            if (bus.id_valid) state_d = IDLE;
        end else if (bus.id_valid) begin
            if (resolve)       state_d = kill_next ? SLOT_KILL : SLOT_EXEC;
            else if (!stall_c) state_d = IDLE;
        end
    end

    // CC register and saturating outcome counters
    always_comb begin
        cc_d         = bus.cc_we ? bus.cc_in : cc_q;
        taken_cnt_d  = taken_cnt_q;
        ntaken_cnt_d = ntaken_cnt_q;
        if (resolve) begin
            if (take) begin
                if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
            end else begin
                if (ntaken_cnt_q != '1) ntaken_cnt_d = ntaken_cnt_q + 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q         <= '0;
            state_q      <= IDLE;
            taken_cnt_q  <= '0;
            ntaken_cnt_q <= '0;
        end else begin
            cc_q         <= cc_d;
            state_q      <= state_d;
            taken_cnt_q  <= taken_cnt_d;
            ntaken_cnt_q <= ntaken_cnt_d;
        end
    end

    assign bus.redirect   = take;
    assign bus.target     = target_c;
    assign bus.squash     = squash_c;
    assign bus.stall      = stall_c;
    assign bus.cc_q       = cc_q;
    assign bus.taken_cnt  = taken_cnt_q;
    assign bus.ntaken_cnt = ntaken_cnt_q;
endmodule
